// File: rtl/bot_video_pkg.sv
// Shared video constants and helpers for the RojoBot icon path.
// Heading codes, sprite geometry, rotation and sprite artwork.
package bot_video_pkg;

  localparam logic [11:0] TRANSPARENT = 12'h000;
  localparam int SPRITE_W = 16;

  localparam logic [2:0] HDG_N  = 3'd0;
  localparam logic [2:0] HDG_NE = 3'd1;
  localparam logic [2:0] HDG_E  = 3'd2;
  localparam logic [2:0] HDG_SE = 3'd3;
  localparam logic [2:0] HDG_S  = 3'd4;
  localparam logic [2:0] HDG_SW = 3'd5;
  localparam logic [2:0] HDG_W  = 3'd6;
  localparam logic [2:0] HDG_NW = 3'd7;

  // Map a screen-relative (u, v) back to the unrotated sprite; {ys, xs}.
  function automatic logic [7:0] rot_coord(
    input logic [3:0] u,
    input logic [3:0] v,
    input logic [1:0] r
  );
    logic [7:0] res;
    unique case (r)
      2'd0:    res = {v, u};
      2'd1:    res = {~u, v};
      2'd2:    res = {~v, ~u};
      default: res = {u, ~v};
    endcase
    return res;
  endfunction

  // Sprite artwork: address {base, ys, xs}; the N tip of the
  // cardinal sprite is red, a sparse diagonal lattice is clear.
  function automatic logic [11:0] sprite_word(input logic [8:0] a);
    logic [4:0]  s;
    logic [11:0] w;
    s = {1'b0, a[3:0]} + {1'b0, a[7:4]};
    if (a == 9'h008)
      w = 12'hF00;
    else if (s % 5'd5 == 5'd0)
      w = TRANSPARENT;
    else
      w = {a[8], 3'b001, a[7:0]};
    return w;
  endfunction

endpackage

// File: rtl/bot_sprite_rom.sv
// 512x12 synchronous-read sprite ROM.
// Words 0-255 hold the cardinal sprite, 256-511 the diagonal one.
import bot_video_pkg::*;

module bot_sprite_rom (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  addr,
  output logic [11:0] data
);

  logic [11:0] data_q;
  logic [11:0] data_d;

  // Table lookup feeding the registered read port.
  always_comb begin
    data_d = sprite_word(addr);
  end

  // Registered read data, cleared with the rest of the pipeline.
  always_ff @(posedge clk) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/bot_sprite_render.sv
// RojoBot icon overlay: frame-latched pose, 8-way heading, blink.
// Three-stage pipeline from pixel coordinates to botIcon/iconHit.
import bot_video_pkg::*;

module bot_sprite_render #(
  parameter int         HALF      = 8,
  parameter logic [3:0] BLINK_ACT = 4'hF,
  parameter int         BLINK_BIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pixCol,
  input  logic [9:0]  pixRow,
  input  logic [9:0]  locX,
  input  logic [9:0]  locY,
  input  logic [7:0]  botInfo,
  output logic [11:0] botIcon,
  output logic        iconHit
);

  logic       cond;
  logic       sof;
  logic       cond_prev_q, cond_prev_d;
  logic [9:0] locx_s_q, locx_s_d;
  logic [9:0] locy_s_q, locy_s_d;
  logic [2:0] hdg_s_q, hdg_s_d;
  logic [3:0] act_s_q, act_s_d;
  logic [5:0] frame_q, frame_d;

  logic [10:0] dx, dy;
  logic [7:0]  src;
  logic        hit1_q, hit1_d;
  logic        vis1_q, vis1_d;
  logic [8:0]  addr1_q, addr1_d;

  logic        hit2_q, hit2_d;
  logic [11:0] rom_data;

  logic [11:0] icon_q, icon_d;
  logic        ihit_q, ihit_d;

  logic unused_info;
  assign unused_info = botInfo[3];

  assign cond = (pixRow == 10'd0) && (pixCol == 10'd0);
  assign sof  = cond && !cond_prev_q;

  // Shadow pose and frame counter; the _d values double as the
  // bypass so pixel (0,0) already sees the freshly latched pose.
  always_comb begin
    cond_prev_d = cond;
    locx_s_d    = locx_s_q;
    locy_s_d    = locy_s_q;
    hdg_s_d     = hdg_s_q;
    act_s_d     = act_s_q;
    frame_d     = frame_q;
    if (sof) begin
      locx_s_d = locX;
      locy_s_d = locY;
      hdg_s_d  = botInfo[2:0];
      act_s_d  = botInfo[7:4];
      frame_d  = frame_q + 6'd1;
    end
  end

  // Stage 1: box test, blink visibility, rotated ROM address.
  always_comb begin
    dx = {1'b0, pixCol} - {1'b0, locx_s_d} + 11'(HALF);
    dy = {1'b0, pixRow} - {1'b0, locy_s_d} + 11'(HALF);
    hit1_d  = (dx < 11'(SPRITE_W)) && (dy < 11'(SPRITE_W));
    vis1_d  = !((act_s_d == BLINK_ACT) && !frame_d[BLINK_BIT]);
    src     = rot_coord(dx[3:0], dy[3:0], hdg_s_d[2:1]);
    addr1_d = {hdg_s_d[0], src};
  end

  // Stages 2 and 3: delayed hit alongside ROM data, then output mux.
  always_comb begin
    hit2_d = hit1_q && vis1_q;
    icon_d = hit2_q ? rom_data : TRANSPARENT;
    ihit_d = hit2_q && (rom_data != TRANSPARENT);
  end

  bot_sprite_rom u_rom (
    .clk   (clk),
    .reset (reset),
    .addr  (addr1_q),
    .data  (rom_data)
  );

  // All state registers; reset overrides a coincident sof.
  always_ff @(posedge clk) begin
    if (reset) begin
      cond_prev_q <= 1'b0;
      locx_s_q    <= '0;
      locy_s_q    <= '0;
      hdg_s_q     <= '0;
      act_s_q     <= '0;
      frame_q     <= '0;
      hit1_q      <= 1'b0;
      vis1_q      <= 1'b0;
      addr1_q     <= '0;
      hit2_q      <= 1'b0;
      icon_q      <= '0;
      ihit_q      <= 1'b0;
    end else begin
      cond_prev_q <= cond_prev_d;
      locx_s_q    <= locx_s_d;
      locy_s_q    <= locy_s_d;
      hdg_s_q     <= hdg_s_d;
      act_s_q     <= act_s_d;
      frame_q     <= frame_d;
      hit1_q      <= hit1_d;
      vis1_q      <= vis1_d;
      addr1_q     <= addr1_d;
      hit2_q      <= hit2_d;
      icon_q      <= icon_d;
      ihit_q      <= ihit_d;
    end
  end

  assign botIcon = icon_q;
  assign iconHit = ihit_q;

endmodule

// File: tb/tb_bot_sprite_render.sv
// Bench for bot_sprite_render: behavioural model checked every
// cycle, plus hand-computed literal expectations.
module tb_bot_sprite_render;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pixCol, pixRow, locX, locY;
  logic [7:0]  botInfo;
  logic [11:0] botIcon;
  logic        iconHit;

  always #5 clk = ~clk;

  bot_sprite_render #(
    .HALF      (8),
    .BLINK_ACT (4'hF),
    .BLINK_BIT (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pixCol  (pixCol),
    .pixRow  (pixRow),
    .locX    (locX),
    .locY    (locY),
    .botInfo (botInfo),
    .botIcon (botIcon),
    .iconHit (iconHit)
  );

  int checks = 0;
  int errors = 0;

  int lx_n = 0, ly_n = 0, info_n = 0;

  int sh_x, sh_y, sh_h, sh_a, frame;
  bit prev_cond;
  bit model_valid = 0;
  logic [11:0] exp_icon [3];
  bit          exp_hit  [3];

  function automatic int sprite(int b, int x, int y);
    if (b == 0 && x == 8 && y == 0) return 'hF00;
    if ((x + y) % 5 == 0) return 0;
    return b * 2048 + 256 + y * 16 + x;
  endfunction

  function automatic void px_expect(int col, int row,
                                    output logic [11:0] icon,
                                    output bit hit);
    int dx, dy, x, y, t;
    icon = 12'h000;
    hit  = 0;
    dx = col - sh_x + 8;
    dy = row - sh_y + 8;
    if (dx < 0 || dx > 15 || dy < 0 || dy > 15) return;
    if (sh_a == 15 && ((frame >> 4) & 1) == 0) return;
    x = dx;
    y = dy;
    for (int k = 0; k < sh_h / 2; k++) begin
      t = x;
      x = y;
      y = 15 - t;
    end
    icon = 12'(sprite(sh_h % 2, x, y));
    hit  = (icon != 12'h000);
  endfunction

  function automatic void model_step(int col, int row, bit rst);
    bit cond;
    logic [11:0] ic;
    bit h;
    if (rst) begin
      sh_x = 0; sh_y = 0; sh_h = 0; sh_a = 0;
      frame = 0;
      prev_cond = 0;
      for (int i = 0; i < 3; i++) begin
        exp_icon[i] = 12'h000;
        exp_hit[i]  = 0;
      end
      model_valid = 1;
      return;
    end
    cond = (col == 0 && row == 0);
    if (cond && !prev_cond) begin
      sh_x = lx_n;
      sh_y = ly_n;
      sh_h = info_n % 8;
      sh_a = info_n / 16;
      frame = (frame + 1) % 64;
    end
    prev_cond = cond;
    px_expect(col, row, ic, h);
    exp_icon[2] = exp_icon[1]; exp_hit[2] = exp_hit[1];
    exp_icon[1] = exp_icon[0]; exp_hit[1] = exp_hit[0];
    exp_icon[0] = ic;          exp_hit[0] = h;
  endfunction

  task automatic step(input int col, input int row, input bit rst);
    int c, r;
    @(negedge clk);
    if (model_valid) begin
      checks++;
      if (botIcon !== exp_icon[2] || iconHit !== exp_hit[2]) begin
        errors++;
        $display("FAIL model t=%0t: botIcon=%h iconHit=%b, expected %h %b",
                 $time, botIcon, iconHit, exp_icon[2], exp_hit[2]);
      end
    end
    c = col & 1023;
    r = row & 1023;
    pixCol  = 10'(c);
    pixRow  = 10'(r);
    reset   = rst;
    locX    = 10'(lx_n);
    locY    = 10'(ly_n);
    botInfo = 8'(info_n);
    model_step(c, r, rst);
  endtask

  task automatic pix(input int col, input int row);
    repeat (4) step(col, row, 0);
  endtask

  task automatic lit(input string name, input logic [11:0] ic,
                     input bit h);
    checks++;
    if (botIcon !== ic || iconHit !== h) begin
      errors++;
      $display("FAIL %s: botIcon=%h iconHit=%b, expected %h %b",
               name, botIcon, iconHit, ic, h);
    end
  endtask

  task automatic frame_start(input int lx, input int ly, input int info);
    lx_n = lx;
    ly_n = ly;
    info_n = info;
    pix(5, 0);
    pix(0, 0);
  endtask

  initial begin
    int lx, ly, col, row, hold;
    reset = 1'b1;
    pixCol = '0; pixRow = '0;
    locX = '0; locY = '0; botInfo = '0;
    model_step(0, 0, 1);
    step(3, 3, 1);
    step(3, 3, 1);
    lit("reset_out", 12'h000, 0);

    // Basic hit and neighbours
    frame_start(100, 60, 8'h00);
    pix(100, 52);  lit("basic_tip", 12'hF00, 1);
    pix(92, 52);   lit("basic_xs0", 12'h000, 0);
    pix(116, 60);  lit("basic_out", 12'h000, 0);

    // Rotations
    frame_start(100, 60, 2);
    pix(107, 60);  lit("rot_E", 12'hF00, 1);
    frame_start(100, 60, 4);
    pix(99, 67);   lit("rot_S", 12'hF00, 1);
    frame_start(100, 60, 6);
    pix(92, 59);   lit("rot_W", 12'hF00, 1);
    frame_start(100, 60, 1);
    pix(95, 56);   lit("diag_NE", 12'h943, 1);
    frame_start(100, 60, 5);
    pix(104, 63);  lit("diag_SW", 12'h943, 1);

    // Tearing
    frame_start(100, 60, 0);
    lx_n = 200;
    pix(3, 300);
    pix(100, 52);  lit("tear_old", 12'hF00, 1);
    pix(200, 52);  lit("tear_new_early", 12'h000, 0);
    frame_start(200, 60, 0);
    pix(200, 52);  lit("tear_new", 12'hF00, 1);

    // Edge clip
    frame_start(4, 4, 0);
    pix(0, 1);     lit("clip_col0", 12'h154, 1);
    pix(1020, 1);  lit("clip_1020", 12'h000, 0);

    // Reset mid-frame while visible
    frame_start(100, 60, 0);
    pix(100, 52);
    step(100, 52, 1);
    step(100, 52, 0);
    lit("rst_mid", 12'h000, 0);
    pix(0, 1);     lit("rst_home", 12'h198, 1);
    frame_start(100, 60, 0);
    pix(100, 52);  lit("rst_relatch", 12'hF00, 1);

    // Blink from a known frame count
    step(7, 7, 1);
    for (int k = 1; k <= 40; k++) begin
      frame_start(100, 60, 8'hF0);
      pix(100, 52);
      if (k == 15) lit("blink_f15", 12'h000, 0);
      if (k == 16) lit("blink_f16", 12'hF00, 1);
      if (k == 31) lit("blink_f31", 12'hF00, 1);
      if (k == 32) lit("blink_f32", 12'h000, 0);
    end
    for (int k = 0; k < 20; k++) begin
      frame_start(100, 60, 8'h10);
      pix(100, 52);
      if (k == 3) lit("noblink", 12'hF00, 1);
    end

    // Randomized frames
    for (int f = 0; f < 60; f++) begin
      lx = $urandom_range(0, 1023);
      ly = $urandom_range(0, 1023);
      info_n = $urandom_range(0, 255);
      if ($urandom_range(0, 2) == 0) info_n = 8'hF0 | (info_n & 15);
      frame_start(lx, ly, info_n);
      for (int p = 0; p < 40; p++) begin
        if ($urandom_range(0, 19) == 0) lx_n = $urandom_range(0, 1023);
        if ($urandom_range(0, 19) == 0) info_n = $urandom_range(0, 255);
        if ($urandom_range(0, 299) == 0) step(9, 9, 1);
        col = lx + $urandom_range(0, 24) - 12;
        row = ly + $urandom_range(0, 24) - 12;
        hold = $urandom_range(1, 4);
        repeat (hold) step(col, row, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
